control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Clock  input  1  system clock; all state changes on rising edge.
REQ-002 Clear  input  1  reset, asynchronous, active-low; Clear=0 forces state Reset_state immediately.
REQ-003 IR  input  32  instruction register contents from datapath; opcode=IR[31:27].
REQ-004 CON  input  1  branch-condition flip-flop output from datapath.
REQ-005 Outputs, 1 bit each unless noted; active-high datapath controls:
- PCout, MDRout, Zlowout, Zhiout
- MARin, MDRin, IRin, PCin, Yin, Zin, CONin
- Read, RAM_write, IncPC
- Gra, Grb, Grc, Rin, Rout, BAout, Cout
REQ-006 ALU_op  output  4  ALU select: ADD=0000, SUB=0001, AND=0010, OR=0011; 0000 whenever Zin=0.
REQ-007 Run  output  1  1 while executing, 0 in Reset_state and Halt.

Function
REQ-008 The block SHALL be a Moore FSM; outputs SHALL depend only on present state, IR[31:27], and CON (CON used in T6 of br only).
REQ-009 States SHALL be Reset_state, T0..T7, Halt; Reset_state->T0 on first edge with Clear=1.
REQ-010 Every output not listed for a state SHALL be 0 in that state.
REQ-011 Fetch SHALL be: T0 PCout,MARin; T1 Read,MDRin; T2 MDRout,IRin,IncPC,PCin; T2->T3 always.
REQ-012 Opcode SHALL be decoded in T3 onward from IR[31:27].
REQ-013 ld (00000): T3 Grb,BAout,Yin; T4 Cout,Zin,ALU_op=ADD; T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin; T7->T0.
REQ-014 ldi (00001): T3,T4 as ld; T5 Zlowout,Gra,Rin; T5->T0.
REQ-015 st (00010): T3..T5 as ld; T6 Gra,Rout,MDRin (Read=0); T7 RAM_write; T7->T0.
REQ-016 add/sub/and/or (00011/00100/00101/00110): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin, ALU_op=ADD/SUB/AND/OR; T5 Zlowout,Gra,Rin; T5->T0.
REQ-017 addi (01100): T3 Grb,Rout,Yin; T4 Cout,Zin,ALU_op=ADD; T5 Zlowout,Gra,Rin; T5->T0.
REQ-018 br (10010): T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin,ALU_op=ADD; T6 Zlowout,PCin only if CON=1, else all outputs 0; T6->T0.
REQ-019 nop (11010) and any undefined opcode SHALL go T3->T0 with T3 outputs all 0.
REQ-020 halt (11011) SHALL go T3->Halt; Halt SHALL hold, all outputs 0, Run=0, until Clear=0.
REQ-021 Exactly one of Gra/Grb/Grc SHALL be 1 in any state asserting Rin, Rout or BAout; Rout and BAout SHALL never both be 1.
REQ-022 At most one bus driver (PCout, MDRout, Zlowout, Zhiout, Rout, BAout, Cout) SHALL be 1 per state.
REQ-023 Instruction latency in clocks from T0 entry to next T0: ld 8, st 8, ldi 6, ALU 6, addi 6, br 7, nop 4.

Reset
REQ-024 Clear=0 SHALL, without a clock edge, set state Reset_state, all control outputs 0, ALU_op=0000, Run=0.
REQ-025 Clear asserted mid-instruction (any of T0..T7, Halt) SHALL abandon it; no RAM_write/Rin pulse SHALL complete afterwards.
REQ-026 After Clear deasserts, Run=1 from the first rising edge (state T0).

Verification
REQ-027 Release Clear, IR=32'h00800055 (ld R1,0x55(R0)) -> T0..T7 with Read in T1 and T6, MDRout+Gra+Rin in T7, back to T0 at clock 9.
REQ-028 IR=32'h19890000 (add R3,R1,R2) -> T4 Grc,Rout,Zin,ALU_op=0000; T5 Gra,Rin; T0 at clock 7.
REQ-029 IR=32'h91000000 (br), CON=1 then CON=0 runs -> T6 Zlowout,PCin only on CON=1 run; both return to T0.
REQ-030 IR=32'h10000000 (st) -> T6 Gra,Rout,MDRin with Read=0; T7 RAM_write=1 for exactly one clock.
REQ-031 IR=32'hD8000000 (halt) -> Halt, Run=0 for 20 clocks; Clear low pulse -> Reset_state, then T0, Run=1.
REQ-032 Clear pulsed low mid-clock during T6 of ld -> outputs 0 before next edge; no Rin seen; restart from T0.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore-style control unit for a simple single-bus datapath. It steps
//   through fetch (T0..T2), decodes IR[31:27] from T3 onward, runs the
//   instruction's micro-steps, and returns to T0. The halt opcode parks the
//   machine in Halt until Clear is pulsed low.
// Ports
//   Clock      system clock, rising edge
//   Clear      asynchronous active-low reset to Reset_state
//   IR[31:0]   instruction register contents (opcode = IR[31:27])
//   CON        branch-condition flag, used only in T6 of br
//   PCout..Cout, MARin..CONin, Read, RAM_write, IncPC, Gra/Grb/Grc,
//   Rin, Rout  one-bit active-high datapath controls
//   ALU_op     ALU select (ADD/SUB/AND/OR), 0000 whenever Zin is low
//   Run        high while executing T0..T7
module control_sequencer (
    input  logic        Clock,
    input  logic        Clear,
    input  logic [31:0] IR,
    input  logic        CON,
    output logic        PCout,
    output logic        MDRout,
    output logic        Zlowout,
    output logic        Zhiout,
    output logic        MARin,
    output logic        MDRin,
    output logic        IRin,
    output logic        PCin,
    output logic        Yin,
    output logic        Zin,
    output logic        CONin,
    output logic        Read,
    output logic        RAM_write,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic [3:0]  ALU_op,
    output logic        Run
);

    typedef enum logic [3:0] {
        Reset_state = 4'd0,
        T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
        T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8,
        Halt = 4'd9
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;

    state_t     state_r;
    state_t     state_next_s;
    logic [4:0] opcode_s;
    logic       unused_ir_s;

    assign opcode_s    = IR[31:27];
    // Operand fields are consumed by the datapath, not by the sequencer.
    assign unused_ir_s = ^IR[26:0];

    // State register; Clear low drops straight to Reset_state.
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_r <= Reset_state;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            Reset_state: state_next_s = T0;
            T0:          state_next_s = T1;
            T1:          state_next_s = T2;
            T2:          state_next_s = T3;
            T3: begin
                case (opcode_s)
                    OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB,
                    OP_AND, OP_OR, OP_ADDI, OP_BR: state_next_s = T4;
                    OP_HALT:                       state_next_s = Halt;
                    default:                       state_next_s = T0;
                endcase
            end
            T4:          state_next_s = T5;
            T5: begin
                case (opcode_s)
                    OP_LD, OP_ST, OP_BR: state_next_s = T6;
                    default:             state_next_s = T0;
                endcase
            end
            T6: begin
                if (opcode_s == OP_BR) begin
                    state_next_s = T0;
                end else begin
                    state_next_s = T7;
                end
            end
            T7:          state_next_s = T0;
            Halt:        state_next_s = Halt;
            default:     state_next_s = Reset_state;
        endcase
    end

    // Control outputs decoded from the present state (and opcode / CON).
    always_comb begin
        PCout = 1'b0; MDRout = 1'b0; Zlowout = 1'b0; Zhiout = 1'b0;
        MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; PCin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; CONin = 1'b0; Read = 1'b0;
        RAM_write = 1'b0; IncPC = 1'b0; Gra = 1'b0; Grb = 1'b0;
        Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0; Cout = 1'b0;
        ALU_op = ALU_ADD;
        Run = 1'b0;
        case (state_r)
            T0: begin Run = 1'b1; PCout = 1'b1; MARin = 1'b1; end
            T1: begin Run = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            T2: begin
                Run = 1'b1; MDRout = 1'b1; IRin = 1'b1; IncPC = 1'b1; PCin = 1'b1;
            end
            T3: begin
                Run = 1'b1;
                case (opcode_s)
                    // Loads/stores add the offset to R[rb], with R0 reading as zero.
                    OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    default: begin end
                endcase
            end
            T4: begin
                Run = 1'b1;
                case (opcode_s)
                    OP_LD, OP_LDI, OP_ST, OP_ADDI: begin Cout = 1'b1; Zin = 1'b1; end
                    OP_ADD: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = ALU_ADD; end
                    OP_SUB: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = ALU_SUB; end
                    OP_AND: begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = ALU_AND; end
                    OP_OR:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALU_op = ALU_OR;  end
                    OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
                    default: begin end
                endcase
            end
            T5: begin
                Run = 1'b1;
                case (opcode_s)
                    OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    OP_BR:   begin Cout = 1'b1; Zin = 1'b1; end
                    default: begin end
                endcase
            end
            T6: begin
                Run = 1'b1;
                case (opcode_s)
                    OP_LD: begin Read = 1'b1; MDRin = 1'b1; end
                    OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    OP_BR: begin
                        // Branch target is only taken when the condition held.
                        if (CON) begin
                            Zlowout = 1'b1; PCin = 1'b1;
                        end else begin
                            Zlowout = 1'b0; PCin = 1'b0;
                        end
                    end
                    default: begin end
                endcase
            end
            T7: begin
                Run = 1'b1;
                case (opcode_s)
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST:   RAM_write = 1'b1;
                    default: begin end
                endcase
            end
            default: begin end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: directed instruction runs followed by
// randomized instruction streams, each clock compared to a step-list model
// derived from the instruction micro-step rules.
module tb_control_sequencer;

    logic        Clock, Clear, CON;
    logic [31:0] IR;
    logic PCout, MDRout, Zlowout, Zhiout, MARin, MDRin, IRin, PCin, Yin, Zin;
    logic CONin, Read, RAM_write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic [3:0] ALU_op;
    logic       Run;

    control_sequencer dut (
        .Clock(Clock), .Clear(Clear), .IR(IR), .CON(CON),
        .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Zhiout(Zhiout),
        .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .PCin(PCin), .Yin(Yin),
        .Zin(Zin), .CONin(CONin), .Read(Read), .RAM_write(RAM_write),
        .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .BAout(BAout), .Cout(Cout), .ALU_op(ALU_op), .Run(Run)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Control word layout: {21 control bits, ALU_op, Run}
    localparam logic [20:0] C_PCOUT = 21'd1 << 20, C_MDROUT = 21'd1 << 19;
    localparam logic [20:0] C_ZLOW  = 21'd1 << 18, C_ZHI    = 21'd1 << 17;
    localparam logic [20:0] C_MARIN = 21'd1 << 16, C_MDRIN  = 21'd1 << 15;
    localparam logic [20:0] C_IRIN  = 21'd1 << 14, C_PCIN   = 21'd1 << 13;
    localparam logic [20:0] C_YIN   = 21'd1 << 12, C_ZIN    = 21'd1 << 11;
    localparam logic [20:0] C_CONIN = 21'd1 << 10, C_READ   = 21'd1 << 9;
    localparam logic [20:0] C_WRITE = 21'd1 << 8,  C_INCPC  = 21'd1 << 7;
    localparam logic [20:0] C_GRA   = 21'd1 << 6,  C_GRB    = 21'd1 << 5;
    localparam logic [20:0] C_GRC   = 21'd1 << 4,  C_RIN    = 21'd1 << 3;
    localparam logic [20:0] C_ROUT  = 21'd1 << 2,  C_BAOUT  = 21'd1 << 1;
    localparam logic [20:0] C_COUT  = 21'd1;

    logic [25:0] obs_w;
    assign obs_w = {PCout, MDRout, Zlowout, Zhiout, MARin, MDRin, IRin, PCin,
                    Yin, Zin, CONin, Read, RAM_write, IncPC, Gra, Grb, Grc,
                    Rin, Rout, BAout, Cout, ALU_op, Run};

    int vectors = 0;
    int miscompares = 0;
    logic [25:0] exp_q[$];
    logic        exp_halts;

    function automatic logic [25:0] w(input logic [20:0] c, input logic [3:0] a);
        return {c, a, 1'b1};
    endfunction

    task automatic check(input string tag, input logic [25:0] exp);
        vectors++;
        assert (obs_w === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs_w, exp);
        end
    endtask

    // Expected per-clock control words from T0 entry until the next T0.
    task automatic build_expected(input logic [31:0] ir, input logic con);
        logic [4:0] op;
        op = ir[31:27];
        exp_halts = 1'b0;
        exp_q.delete();
        exp_q.push_back(w(C_PCOUT | C_MARIN, 4'd0));
        exp_q.push_back(w(C_READ | C_MDRIN, 4'd0));
        exp_q.push_back(w(C_MDROUT | C_IRIN | C_INCPC | C_PCIN, 4'd0));
        if (op == 5'd0 || op == 5'd1 || op == 5'd2) begin
            exp_q.push_back(w(C_GRB | C_BAOUT | C_YIN, 4'd0));
            exp_q.push_back(w(C_COUT | C_ZIN, 4'd0));
            if (op == 5'd1) begin
                exp_q.push_back(w(C_ZLOW | C_GRA | C_RIN, 4'd0));
            end else begin
                exp_q.push_back(w(C_ZLOW | C_MARIN, 4'd0));
                if (op == 5'd0) begin
                    exp_q.push_back(w(C_READ | C_MDRIN, 4'd0));
                    exp_q.push_back(w(C_MDROUT | C_GRA | C_RIN, 4'd0));
                end else begin
                    exp_q.push_back(w(C_GRA | C_ROUT | C_MDRIN, 4'd0));
                    exp_q.push_back(w(C_WRITE, 4'd0));
                end
            end
        end else if (op >= 5'd3 && op <= 5'd6) begin
            exp_q.push_back(w(C_GRB | C_ROUT | C_YIN, 4'd0));
            exp_q.push_back(w(C_GRC | C_ROUT | C_ZIN, 4'(op - 5'd3)));
            exp_q.push_back(w(C_ZLOW | C_GRA | C_RIN, 4'd0));
        end else if (op == 5'd12) begin
            exp_q.push_back(w(C_GRB | C_ROUT | C_YIN, 4'd0));
            exp_q.push_back(w(C_COUT | C_ZIN, 4'd0));
            exp_q.push_back(w(C_ZLOW | C_GRA | C_RIN, 4'd0));
        end else if (op == 5'd18) begin
            exp_q.push_back(w(C_GRA | C_ROUT | C_CONIN, 4'd0));
            exp_q.push_back(w(C_PCOUT | C_YIN, 4'd0));
            exp_q.push_back(w(C_COUT | C_ZIN, 4'd0));
            exp_q.push_back(w(con ? (C_ZLOW | C_PCIN) : 21'd0, 4'd0));
        end else begin
            exp_q.push_back(w(21'd0, 4'd0));
            exp_halts = (op == 5'd27);
        end
    endtask

    // Entered just after a rising edge with the DUT in T0.
    task automatic run_instr(input string tag, input logic [31:0] ir, input logic con);
        IR = ir;
        CON = con;
        build_expected(ir, con);
        foreach (exp_q[i]) begin
            check($sformatf("%s_step%0d", tag, i), exp_q[i]);
            @(posedge Clock); #1;
        end
        if (exp_halts) begin
            for (int k = 0; k < 20; k++) begin
                check($sformatf("%s_halt%0d", tag, k), 26'd0);
                @(posedge Clock); #1;
            end
        end else begin
            check($sformatf("%s_back_to_T0", tag), w(C_PCOUT | C_MARIN, 4'd0));
        end
    endtask

    initial begin
        logic [4:0]  op;
        logic [4:0]  defined_ops [10];
        logic [4:0]  undef_ops [4];
        defined_ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd12, 5'd18, 5'd26};
        undef_ops   = '{5'd7, 5'd8, 5'd16, 5'd31};

        Clear = 1'b0; IR = 32'd0; CON = 1'b0;
        #3;
        check("reset_async", 26'd0);
        @(posedge Clock); #1;
        check("reset_hold", 26'd0);
        @(negedge Clock);
        Clear = 1'b1;
        @(posedge Clock); #1;

        run_instr("ld",     32'h00800055, 1'b0);
        run_instr("add",    32'h19890000, 1'b0);
        run_instr("br_t",   32'h91000000, 1'b1);
        run_instr("br_nt",  32'h91000000, 1'b0);
        run_instr("st",     32'h10000000, 1'b0);
        run_instr("nop",    32'hD0000000, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = undef_ops[$urandom_range(0, 3)];
            end else begin
                op = defined_ops[$urandom_range(0, 9)];
            end
            run_instr($sformatf("rnd%0d_op%0d", n, op),
                      {op, 27'($urandom)}, 1'($urandom));
        end

        // Clear pulsed mid-cycle during T6 of ld.
        IR = 32'h00800055; CON = 1'b0;
        build_expected(IR, CON);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("ldclr_step%0d", i), exp_q[i]);
            if (i < 6) begin
                @(posedge Clock); #1;
            end
        end
        #2 Clear = 1'b0;
        #1 check("ldclr_outputs_zero", 26'd0);
        #1 Clear = 1'b1;
        @(posedge Clock); #1;
        check("ldclr_restart_T0", w(C_PCOUT | C_MARIN, 4'd0));

        // Halt, then recover via Clear.
        run_instr("halt", 32'hD8000000, 1'b0);
        #2 Clear = 1'b0;
        #1 check("halt_clear_zero", 26'd0);
        @(negedge Clock);
        Clear = 1'b1;
        @(posedge Clock); #1;
        check("halt_restart_T0", w(C_PCOUT | C_MARIN, 4'd0));
        run_instr("post_halt_addi", 32'h60880007, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
